// File: rtl/scaled_clock.sv
// scaled_clock: divides clock into a registered 50%-duty square wave with a rising-edge tick
module scaled_clock #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int OUT_FREQ_HZ = 1
) (
  input  logic clock,
  input  logic reset,
  output logic scaledclk,
  output logic tick
);
  localparam int HALF_PERIOD = (OUT_FREQ_HZ >= 1) ? CLK_FREQ_HZ / (2 * OUT_FREQ_HZ) : 1;
  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);
  if (OUT_FREQ_HZ < 1) begin : g_bad_out
    $fatal(1, "scaled_clock: OUT_FREQ_HZ must be at least 1");
  end
  if (CLK_FREQ_HZ < 2 * OUT_FREQ_HZ) begin : g_bad_ratio
    $fatal(1, "scaled_clock: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
  end
  if ((OUT_FREQ_HZ >= 1) && (CLK_FREQ_HZ % (2 * OUT_FREQ_HZ) != 0)) begin : g_bad_div
    $fatal(1, "scaled_clock: CLK_FREQ_HZ must be an exact multiple of 2*OUT_FREQ_HZ");
  end
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scaledclk_q, scaledclk_d;
  logic             tick_q, tick_d;
  logic             last;
  // next state: wrap and toggle at the terminal count, otherwise count up and hold
  always_comb begin
    last        = (cnt_q == LAST);
    cnt_d       = last ? '0 : cnt_q + CNT_W'(1);
    scaledclk_d = last ? ~scaledclk_q : scaledclk_q;
    tick_d      = last & ~scaledclk_q;
  end
  // state registers; reset restarts the phase from zero
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      scaledclk_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      scaledclk_q <= scaledclk_d;
      tick_q      <= tick_d;
    end
  end
  assign scaledclk = scaledclk_q;
  assign tick      = tick_q;
endmodule

// File: tb/tb_scaled_clock.sv
// tb_scaled_clock: checks three divider configurations against an edge-count reference model
module tb_scaled_clock;
  localparam int HA = 5;
  localparam int HB = 1;
  localparam int HC = 50;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sc_a, tk_a, sc_b, tk_b, sc_c, tk_c;
  int n = 0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clock = ~clock;
  scaled_clock #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) u_a (
    .clock(clock), .reset(reset), .scaledclk(sc_a), .tick(tk_a));
  scaled_clock #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) u_b (
    .clock(clock), .reset(reset), .scaledclk(sc_b), .tick(tk_b));
  scaled_clock #(.CLK_FREQ_HZ(300), .OUT_FREQ_HZ(3)) u_c (
    .clock(clock), .reset(reset), .scaledclk(sc_c), .tick(tk_c));
  function automatic logic exp_sc(input int e, input int h);
    return ((e / h) % 2) == 1;
  endfunction
  function automatic logic exp_tk(input int e, input int h);
    return (e > 0) && ((e % (2 * h)) == h);
  endfunction
  task automatic check(input string tag, input logic got, input logic want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s edge %0d: got %0b expected %0b", tag, n, got, want);
    end
  endtask
  task automatic step(input logic r);
    reset = r;
    @(posedge clock);
    n = r ? 0 : n + 1;
    #1;
    check("a_scaledclk", sc_a, exp_sc(n, HA));
    check("a_tick", tk_a, exp_tk(n, HA));
    check("b_scaledclk", sc_b, exp_sc(n, HB));
    check("b_tick", tk_b, exp_tk(n, HB));
    check("c_scaledclk", sc_c, exp_sc(n, HC));
    check("c_tick", tk_c, exp_tk(n, HC));
  endtask
  initial begin
    repeat (3) step(1'b1);
    repeat (40) step(1'b0);
    step(1'b1);
    repeat (7) step(1'b0);
    check("mid_before_reset_high", sc_a, 1'b1);
    step(1'b1);
    check("mid_reset_clears", sc_a, 1'b0);
    repeat (4) step(1'b0);
    check("mid_no_early_rise", sc_a, 1'b0);
    step(1'b0);
    check("mid_rise_after_5", sc_a, 1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (4) step(1'b0);
    step(1'b1);
    check("tc_reset_sc", sc_a, 1'b0);
    check("tc_reset_tick", tk_a, 1'b0);
    repeat (6) step(1'b0);
    repeat (600) step($urandom_range(0, 59) == 0);
    step(1'b1);
    repeat (250) step(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
